// File: rtl/uart_transceiver.sv
// uart_transceiver: parametrised full-duplex UART.
// 16x oversampled RX with mid-bit sampling, valid/ready both ways.
module uart_transceiver #(
   parameter int CLK_DIV   = 27,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   input  logic                 err_clear,
   output logic [2:0]           error_flags
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic PAR_EN  = (PARITY != 0);
   localparam logic PAR_ODD = (PARITY == 2);

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT
   } rx_state_e;

   tx_state_e tx_state_q, tx_state_d;
   logic [DIV_W-1:0] tx_div_q, tx_div_d;
   logic [3:0] tx_os_q, tx_os_d;
   logic [3:0] tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic tx_par_q, tx_par_d;
   logic tx_out_q, tx_out_d;
   logic tx_rdy_q, tx_rdy_d;
   logic tx_tick, tx_bit_end;

   rx_state_e rx_state_q, rx_state_d;
   logic rx_meta_q, rx_meta_d;
   logic rx_sync_q, rx_sync_d;
   logic rx_prev_q, rx_prev_d;
   logic [DIV_W-1:0] rx_div_q, rx_div_d;
   logic [3:0] rx_os_q, rx_os_d;
   logic [3:0] rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic rx_perr_q, rx_perr_d;
   logic rx_tick, rx_mid, rx_half;
   logic rx_done, rx_ferr;

   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic rx_valid_q, rx_valid_d;
   logic [2:0] err_q, err_d;

   assign tx_ready    = tx_rdy_q;
   assign uart_tx     = tx_out_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign error_flags = err_q;

   // TX next state: bit timer, frame sequencing and line level
   always_comb begin
      tx_state_d = tx_state_q;
      tx_div_d   = tx_div_q;
      tx_os_d    = tx_os_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_out_d   = tx_out_q;
      tx_rdy_d   = tx_rdy_q;
      tx_tick    = (tx_div_q == DIV_MAX);
      tx_bit_end = tx_tick && (tx_os_q == 4'd15);
      if (tx_state_q != TX_IDLE) begin
         tx_div_d = tx_tick ? '0 : tx_div_q + DIV_ONE;
         if (tx_tick) tx_os_d = tx_os_q + 4'd1;
      end
      unique case (tx_state_q)
         TX_IDLE: begin
            if (tx_valid) begin
               tx_state_d = TX_START;
               tx_shift_d = tx_data;
               tx_par_d   = (^tx_data) ^ PAR_ODD;
               tx_out_d   = 1'b0;
               tx_rdy_d   = 1'b0;
               tx_div_d   = '0;
               tx_os_d    = '0;
               tx_bit_d   = '0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_out_d   = tx_shift_q[0];
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               if (tx_bit_q == DATA_LAST) begin
                  tx_bit_d = '0;
                  if (PAR_EN) begin
                     tx_state_d = TX_PARITY;
                     tx_out_d   = tx_par_q;
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_out_d   = 1'b1;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + 4'd1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_out_d   = tx_shift_q[1];
               end
            end
         end
         TX_PARITY: begin
            if (tx_bit_end) begin
               tx_state_d = TX_STOP;
               tx_out_d   = 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               if (tx_bit_q == STOP_LAST) begin
                  tx_state_d = TX_IDLE;
                  tx_rdy_d   = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_out_d   = 1'b1;
            tx_rdy_d   = 1'b1;
         end
      endcase
   end

   // TX registers; reset abandons any frame and idles the line high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_div_q   <= '0;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_out_q   <= 1'b1;
         tx_rdy_q   <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_os_q    <= tx_os_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_out_q   <= tx_out_d;
         tx_rdy_q   <= tx_rdy_d;
      end
   end

   // RX next state: synchroniser, oversample timer, frame decode
   always_comb begin
      rx_meta_d  = uart_rx;
      rx_sync_d  = rx_meta_q;
      rx_prev_d  = rx_sync_q;
      rx_state_d = rx_state_q;
      rx_div_d   = rx_div_q;
      rx_os_d    = rx_os_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_perr_d  = rx_perr_q;
      rx_done    = 1'b0;
      rx_ferr    = 1'b0;
      rx_tick    = (rx_div_q == DIV_MAX);
      rx_mid     = rx_tick && (rx_os_q == 4'd15);
      rx_half    = rx_tick && (rx_os_q == 4'd7);
      if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT) begin
         rx_div_d = rx_tick ? '0 : rx_div_q + DIV_ONE;
         if (rx_tick) rx_os_d = rx_os_q + 4'd1;
      end
      unique case (rx_state_q)
         RX_IDLE: begin
            // prev resets low, so a line stuck low never arms RX
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               rx_div_d   = '0;
               rx_os_d    = '0;
               rx_bit_d   = '0;
               rx_perr_d  = 1'b0;
            end
         end
         RX_START: begin
            if (rx_half) begin
               rx_os_d    = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_mid) begin
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == DATA_LAST) begin
                  rx_bit_d   = '0;
                  rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 4'd1;
               end
            end
         end
         RX_PARITY: begin
            if (rx_mid) begin
               rx_perr_d  = rx_sync_q ^ (^rx_shift_q) ^ PAR_ODD;
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_mid) begin
               if (!rx_sync_q) begin
                  rx_ferr    = 1'b1;
                  rx_state_d = RX_WAIT;
               end else if (rx_bit_q == STOP_LAST) begin
                  rx_done    = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_bit_d = rx_bit_q + 4'd1;
               end
            end
         end
         RX_WAIT: begin
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // RX delivery, overrun and sticky error flags
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q && !rx_ready;
      err_d      = err_clear ? 3'b000 : err_q;
      if (rx_ferr) err_d[0] = 1'b1;
      if (rx_done) begin
         if (rx_perr_q) err_d[1] = 1'b1;
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end else begin
            err_d[2] = 1'b1;
         end
      end
   end

   // RX registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q  <= 1'b0;
         rx_sync_q  <= 1'b0;
         rx_prev_q  <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_div_q   <= '0;
         rx_os_q    <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_perr_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         err_q      <= 3'b000;
      end else begin
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         rx_state_q <= rx_state_d;
         rx_div_q   <= rx_div_d;
         rx_os_q    <= rx_os_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_perr_q  <= rx_perr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: random frames vs a frame-level reference model.
// Loopback or bench-driven serial line, 8E2 at CLK_DIV=4.
module tb_uart_transceiver;

   localparam int CD   = 4;
   localparam int BITC = 16 * CD;
   localparam int NB   = 12;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic       uart_rx;
   logic       uart_tx;
   logic       err_clear = 1'b0;
   logic [2:0] error_flags;
   logic       loop = 1'b1;
   logic       drv = 1'b1;

   int n_chk = 0;
   int n_bad = 0;
   bit exp_bits[$];
   logic [7:0] exp_rx[$];
   logic [7:0] got[$];

   assign uart_rx = loop ? uart_tx : drv;

   uart_transceiver #(
      .CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)
   ) dut (
      .clk(clk), .reset(reset),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .uart_rx(uart_rx), .uart_tx(uart_tx),
      .err_clear(err_clear), .error_flags(error_flags)
   );

   always #5 clk = ~clk;

   // consumer side: record every accepted word
   always @(negedge clk)
      if (reset && rx_valid && rx_ready) got.push_back(rx_data);

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // reference frame: start, data LSB first, even parity, 2 stops
   task automatic make_frame(input logic [7:0] d, input bit bad_par,
                             input bit bad_stop);
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
      exp_bits.push_back((^d) ^ bad_par);
      exp_bits.push_back(!bad_stop);
      exp_bits.push_back(!bad_stop);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_frame(input logic [7:0] d, input bit hold);
      make_frame(d, 1'b0, 1'b0);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_data  = 8'($urandom);
      tx_valid = hold;
      for (int k = 0; k < NB * BITC; k++) begin
         chk("tx_line", uart_tx, exp_bits[k / BITC]);
         chk("tx_busy", tx_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      chk("tx_ready_back", tx_ready, 1'b1);
      chk("tx_idle_high", uart_tx, 1'b1);
   endtask

   task automatic drive_frame(input logic [7:0] d, input bit bad_par,
                              input bit bad_stop);
      make_frame(d, bad_par, bad_stop);
      for (int i = 0; i < exp_bits.size(); i++) begin
         drv = exp_bits[i];
         repeat (BITC) @(posedge clk);
         #1;
      end
   endtask

   task automatic rx_match(input string tag);
      chk({tag, "_count"}, got.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size() && i < got.size(); i++)
         chk({tag, "_word"}, got[i], exp_rx[i]);
      got.delete();
      exp_rx.delete();
   endtask

   task automatic clear_pulse();
      err_clear = 1'b1;
      @(posedge clk);
      #1;
      err_clear = 1'b0;
   endtask

   logic [7:0] d;

   initial begin
      idle(3);
      chk("rst_tx", uart_tx, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_valid", rx_valid, 1'b0);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_flags", error_flags, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      idle(10);

      // back-to-back loopback: fixed pair then random words
      for (int i = 0; i < 4; i++) begin
         if (i == 0) d = 8'h3C;
         else if (i == 1) d = 8'hFF;
         else d = 8'($urandom);
         exp_rx.push_back(d);
         tx_frame(d, i < 3);
      end
      idle(20);
      rx_match("loopback");
      chk("loop_flags", error_flags, 3'b000);

      // short glitch is rejected as a false start
      loop = 1'b0;
      drv  = 1'b1;
      idle(20);
      drv = 1'b0;
      idle(24);
      drv = 1'b1;
      idle(400);
      chk("glitch_count", got.size(), 0);
      chk("glitch_valid", rx_valid, 1'b0);
      chk("glitch_flags", error_flags, 3'b000);

      // bad stop then held break, then a good frame
      drive_frame(8'h55, 1'b0, 1'b1);
      drv = 1'b0;
      idle(200);
      drv = 1'b1;
      idle(100);
      chk("frm_flags", error_flags, 3'b001);
      chk("frm_valid", rx_valid, 1'b0);
      chk("frm_count", got.size(), 0);
      drive_frame(8'h12, 1'b0, 1'b0);
      idle(50);
      exp_rx.push_back(8'h12);
      rx_match("after_frm");
      chk("frm_sticky", error_flags, 3'b001);
      clear_pulse();
      chk("frm_clear", error_flags, 3'b000);

      // wrong parity: word still delivered, parity flag set
      d = 8'($urandom);
      idle(30);
      drive_frame(d, 1'b1, 1'b0);
      idle(50);
      exp_rx.push_back(d);
      rx_match("par");
      chk("par_flags", error_flags, 3'b010);
      clear_pulse();
      chk("par_clear", error_flags, 3'b000);

      // overrun: consumer stalled across two frames
      loop = 1'b1;
      rx_ready = 1'b0;
      idle(10);
      tx_frame(8'h11, 1'b1);
      tx_frame(8'h22, 1'b0);
      idle(20);
      chk("ovr_valid", rx_valid, 1'b1);
      chk("ovr_data", rx_data, 8'h11);
      chk("ovr_flags", error_flags, 3'b100);
      clear_pulse();
      chk("ovr_clear", error_flags, 3'b000);
      rx_ready = 1'b1;
      idle(2);
      chk("ovr_drained", rx_valid, 1'b0);
      exp_rx.push_back(8'h11);
      rx_match("ovr");

      // async reset mid-frame, then a clean frame
      d = 8'($urandom);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (3 * BITC + 20) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_tx", uart_tx, 1'b1);
      chk("arst_ready", tx_ready, 1'b1);
      chk("arst_valid", rx_valid, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      idle(10);
      exp_rx.push_back(8'h80);
      tx_frame(8'h80, 1'b0);
      idle(20);
      rx_match("post_rst");
      chk("post_rst_flags", error_flags, 3'b000);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Parametrised full-duplex UART for the FPGA link, replacing the fixed 8N1 transceiver. It provides configurable data bits, parity and stop bits, and 16x oversampled receive with mid-bit sampling and false-start rejection. Both directions use valid/ready handshakes toward the fabric. Error flags are sticky and cleared by software.

Parameters:
CLK_DIV, 27, clocks per oversample tick; bit period = 16*CLK_DIV clocks (50 MHz -> ~115200 baud); legal range 1..65535
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tx_data  in  DATA_BITS  byte to send, sampled on handshake
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter idle, can accept
rx_data  out  DATA_BITS  received word
rx_valid  out  1  rx_data holds an unread word
rx_ready  in  1  consumer accepts rx_data
uart_rx  in  1  serial input, asynchronous
uart_tx  out  1  serial output, idle high
err_clear  in  1  one-cycle pulse clears error_flags
error_flags  out  3  sticky: [0] framing, [1] parity, [2] overrun

Behaviour:
- Reset (reset low, asynchronous) sets: uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, error_flags=0, both FSMs IDLE, all counters 0. A frame in progress is abandoned. After release, RX waits for uart_rx to read high before arming.
- Frame: start bit (0), then DATA_BITS bits LSB first, then the parity bit if PARITY!=0, then STOP_BITS stop bits (1).
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - Handshake is tx_valid && tx_ready in IDLE. On handshake, tx_data is latched and tx_ready drops.
  - uart_tx goes low on the next clock edge. Each bit lasts exactly 16*CLK_DIV clocks, timed by a TX-private counter restarted at the handshake.
  - PARITY is skipped when PARITY=0. Even parity = XOR of data bits; odd parity = its inverse.
  - tx_ready reasserts on the cycle after the last stop bit ends. Back-to-back frames therefore have no idle gap beyond that one cycle.
  - Changes to tx_data and tx_valid while busy are ignored.
- RX synchronisation: uart_rx passes through a 2-flop synchroniser (2-cycle latency). All RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE -> START on a synchronised high-to-low transition.
  - START: the line is re-sampled after 8 ticks (mid-bit). If high, it is a false start and the FSM returns to IDLE with no flag. If low, go to DATA.
  - DATA and PARITY: sample every 16 ticks thereafter (mid-bit).
  - STOP: sample each stop bit at mid-bit. If any stop sample is 0, set error_flags[0], discard the word and go to WAIT_IDLE. WAIT_IDLE -> IDLE once the line reads 1 (handles break).
  - A good stop completes the frame at the mid-point of the last stop bit, then returns to IDLE. This allows the next start edge to be detected within the remaining half bit.
- RX output:
  - On frame completion with rx_valid=0: rx_data <= word and rx_valid <= 1 on the same edge.
  - Parity mismatch: the word is still delivered and error_flags[1] is set.
  - rx_valid clears on the edge where rx_valid && rx_ready.
  - If a frame completes while rx_valid=1 and rx_ready=0: set error_flags[2], drop the new word and keep the old one.
  - If completion coincides with rx_valid && rx_ready: the new word is loaded, rx_valid stays 1 and there is no overrun.
- Errors: each flag is sticky until err_clear. If a flag sets and err_clear is asserted in the same cycle, the set wins.
- Widths: the tick counter is sized ceil(log2(CLK_DIV+1)). The bit counter is 4 bits. There is no arithmetic overflow beyond these counters.

Test Plan:
- CLK_DIV=4, 8N1: send tx_data=0xA5 -> uart_tx reads 0, 1,0,1,0,0,1,0,1, 1, each bit exactly 64 clocks. tx_ready is low for 640 clocks, then high.
- Loopback uart_tx->uart_rx, PARITY=1, STOP_BITS=2: send 0x3C then 0xFF back-to-back -> rx_data=0x3C, then 0xFF. error_flags=0.
- Drive a 24-clock low glitch on uart_rx (less than half a bit) -> no rx_valid, RX returns to IDLE, error_flags=0.
- Frame 0x55 with stop bit forced 0, line held low for 200 clocks, then released -> error_flags=3'b001, no rx_valid. A following good frame 0x12 is received correctly.
- Two frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, error_flags[2]=1. Pulse err_clear -> flags=0.
- Assert reset mid-TX at bit 3 -> uart_tx=1 and tx_ready=1 immediately (asynchronously). After release, a new frame 0x80 transmits cleanly.
